// File: rtl/calc_op_scheduler_if.sv
// Handshake bundles for the calculator op scheduler: request channels, response
// channel and the link to the shared combinational arithmetic datapath.
interface calc_req_if #(
  parameter int unsigned DW = 4
);
  logic          valid;
  logic          ready;
  logic [1:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;

  modport master (output valid, op, a, b, input ready);
  modport slave  (input valid, op, a, b, output ready);
endinterface

interface calc_rsp_if #(
  parameter int unsigned DW = 4
);
  logic            valid;
  logic            ready;
  logic            id;
  logic [2*DW-1:0] result;
  logic [2*DW-1:0] remainder;
  logic            zero_div;

  modport master (output valid, id, result, remainder, zero_div, input ready);
  modport slave  (input valid, id, result, remainder, zero_div, output ready);
endinterface

interface calc_dp_if #(
  parameter int unsigned DW = 4
);
  logic [1:0]      op;
  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic [2*DW-1:0] result;
  logic [2*DW-1:0] remainder;
  logic            zero_div;

  modport master (output op, a, b, input result, remainder, zero_div);
  modport slave  (input op, a, b, output result, remainder, zero_div);
endinterface

// File: rtl/calc_op_scheduler.sv
// Round-robin scheduler sharing one combinational arithmetic datapath between two
// requesters: registers operands, waits a settle window, captures and returns the result.
module calc_op_scheduler #(
  parameter int unsigned DW            = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  calc_req_if.slave  req0_i,
  calc_req_if.slave  req1_i,
  calc_rsp_if.master rsp_o,
  calc_dp_if.master  dp_o,
  output logic       busy_o
);

  localparam int unsigned RW = 2 * DW;
  localparam int unsigned CW = 4;
  localparam logic [1:0]  OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic [1:0]    dp_op_q, dp_op_d;
  logic [DW-1:0] dp_a_q, dp_a_d;
  logic [DW-1:0] dp_b_q, dp_b_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [RW-1:0] rsp_result_q, rsp_result_d;
  logic [RW-1:0] rsp_rem_q, rsp_rem_d;
  logic          rsp_zd_q, rsp_zd_d;
  logic          busy_q, busy_d;

  logic          grant_c;
  logic          ready0_c, ready1_c;
  logic [1:0]    sel_op_c;
  logic [DW-1:0] sel_a_c, sel_b_c;

  // Requester selection: alternate on contention, otherwise serve whoever asks.
  always_comb begin
    if (req0_i.valid && req1_i.valid) grant_c = ~last_grant_q;
    else                              grant_c = req1_i.valid;
    sel_op_c = grant_c ? req1_i.op : req0_i.op;
    sel_a_c  = grant_c ? req1_i.a  : req0_i.a;
    sel_b_c  = grant_c ? req1_i.b  : req0_i.b;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    dp_op_d      = dp_op_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_zd_d     = rsp_zd_q;
    ready0_c     = 1'b0;
    ready1_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_i.valid || req1_i.valid) begin
          ready0_c     = ~grant_c;
          ready1_c     = grant_c;
          dp_op_d      = sel_op_c;
          dp_a_d       = sel_a_c;
          dp_b_d       = sel_b_c;
          rsp_id_d     = grant_c;
          last_grant_d = grant_c;
          cnt_d        = CW'(SETTLE_CYCLES - 1);
          if (sel_op_c == OP_DIV && sel_b_c == '0) begin
            // Divide-by-zero skips the datapath; rsp_valid follows one edge later.
            rsp_result_d = '0;
            rsp_rem_d    = '0;
            rsp_zd_d     = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_result_d = dp_o.result;
          rsp_rem_d    = (dp_op_q == OP_DIV) ? dp_o.remainder : '0;
          rsp_zd_d     = dp_o.zero_div;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_o.ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      dp_op_q      <= '0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_rem_q    <= '0;
      rsp_zd_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      dp_op_q      <= dp_op_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_zd_q     <= rsp_zd_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_i.ready    = ready0_c;
  assign req1_i.ready    = ready1_c;
  assign dp_o.op         = dp_op_q;
  assign dp_o.a          = dp_a_q;
  assign dp_o.b          = dp_b_q;
  assign rsp_o.valid     = rsp_valid_q;
  assign rsp_o.id        = rsp_id_q;
  assign rsp_o.result    = rsp_result_q;
  assign rsp_o.remainder = rsp_rem_q;
  assign rsp_o.zero_div  = rsp_zd_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Bench for calc_op_scheduler: directed scenarios then random traffic, checked every
// cycle against a transaction-level model of arbitration, latency and results.
module tb_calc_op_scheduler;

  localparam int unsigned DW = 4;
  localparam int unsigned RW = 2 * DW;
  localparam int unsigned S  = 2;

  typedef struct packed {
    logic [RW-1:0] res;
    logic [RW-1:0] rem;
    logic          zd;
  } res_t;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct {
    logic          id;
    logic [RW-1:0] res;
    logic [RW-1:0] rem;
    logic          zd;
  } got_t;

  logic clk;
  logic rst_n;
  logic busy;

  calc_req_if #(.DW(DW)) req0_if ();
  calc_req_if #(.DW(DW)) req1_if ();
  calc_rsp_if #(.DW(DW)) rsp_if ();
  calc_dp_if  #(.DW(DW)) dp_if ();

  calc_op_scheduler #(.DW(DW), .SETTLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0_i (req0_if),
    .req1_i (req1_if),
    .rsp_o  (rsp_if),
    .dp_o   (dp_if),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed two's-complement arithmetic; division truncates toward zero.
  function automatic res_t calc(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    res_t r;
    int   sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = '0;
    case (op)
      2'b00: r.res = RW'(sa + sb);
      2'b01: r.res = RW'(sa - sb);
      2'b10: r.res = RW'(sa * sb);
      default: begin
        if (sb == 0) r.zd = 1'b1;
        else begin
          r.res = RW'(sa / sb);
          r.rem = RW'(sa % sb);
        end
      end
    endcase
    return r;
  endfunction

  // Stand-in for the shared arithmetic datapath.
  always_comb begin
    res_t d;
    d = calc(dp_if.op, dp_if.a, dp_if.b);
    dp_if.result    = d.res;
    dp_if.remainder = d.rem;
    dp_if.zero_div  = d.zd;
  end

  int   n_vec;
  int   n_err;
  op_t  q0[$];
  op_t  q1[$];
  got_t got[$];
  bit   rr_rand;
  bit   rr_val;

  // Transaction-level model of the scheduler
  bit            m_free, m_last, m_vis, m_id;
  int            m_wait;
  res_t          m_pend, m_rsp;
  logic [1:0]    m_op;
  logic [DW-1:0] m_a, m_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_free = 1'b1; m_last = 1'b1; m_vis = 1'b0; m_id = 1'b0; m_wait = 0;
    m_pend = '0; m_rsp = '0; m_op = '0; m_a = '0; m_b = '0;
  endtask

  task automatic step();
    bit v0, v1, g;
    op_t o;
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_if.valid), 64'(m_vis));
    chk("rsp_id", 64'(rsp_if.id), 64'(m_id));
    chk("rsp_result", 64'(rsp_if.result), 64'(m_rsp.res));
    chk("rsp_remainder", 64'(rsp_if.remainder), 64'(m_rsp.rem));
    chk("rsp_zero_div", 64'(rsp_if.zero_div), 64'(m_rsp.zd));
    chk("busy", 64'(busy), 64'(!m_free));
    chk("dp_op", 64'(dp_if.op), 64'(m_op));
    chk("dp_a", 64'(dp_if.a), 64'(m_a));
    chk("dp_b", 64'(dp_if.b), 64'(m_b));

    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    req0_if.valid = v0;
    req1_if.valid = v1;
    if (v0) begin req0_if.op = q0[0].op; req0_if.a = q0[0].a; req0_if.b = q0[0].b; end
    if (v1) begin req1_if.op = q1[0].op; req1_if.a = q1[0].a; req1_if.b = q1[0].b; end
    rsp_if.ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    #1;

    g = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", 64'(req0_if.ready), 64'(m_free && v0 && !g));
    chk("req1_ready", 64'(req1_if.ready), 64'(m_free && v1 && g));

    if (m_free && (v0 || v1)) begin
      o = g ? q1.pop_front() : q0.pop_front();
      m_free = 1'b0; m_last = g; m_id = g;
      m_op = o.op; m_a = o.a; m_b = o.b;
      m_pend = calc(o.op, o.a, o.b);
      if (m_pend.zd) begin
        m_rsp  = m_pend;
        m_wait = 1;
      end else begin
        m_wait = S;
      end
    end else if (!m_free) begin
      if (m_vis) begin
        if (rsp_if.ready) begin
          got.push_back('{id: rsp_if.id, res: rsp_if.result, rem: rsp_if.remainder, zd: rsp_if.zero_div});
          m_vis  = 1'b0;
          m_free = 1'b1;
        end
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_vis = 1'b1;
          m_rsp = m_pend;
        end
      end
    end
  endtask

  task automatic push(input bit who, input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_t o;
    o.op = op; o.a = a; o.b = b;
    if (who) q1.push_back(o);
    else     q0.push_back(o);
  endtask

  initial begin
    op_t o;
    n_vec = 0; n_err = 0;
    rr_rand = 1'b0; rr_val = 1'b1;
    rst_n = 1'b0;
    req0_if.valid = 1'b0; req0_if.op = '0; req0_if.a = '0; req0_if.b = '0;
    req1_if.valid = 1'b0; req1_if.op = '0; req1_if.a = '0; req1_if.b = '0;
    rsp_if.ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_if.valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_dp_a", 64'(dp_if.a), 64'(0));
    rst_n = 1'b1;

    // Contention straight out of reset: req0 first, then req1, then req0 again.
    push(1'b0, 2'b00, 4'd3, 4'd4);
    push(1'b1, 2'b10, 4'd3, 4'hE);
    repeat (10) step();
    push(1'b0, 2'b00, 4'd1, 4'd1);
    push(1'b1, 2'b01, 4'd1, 4'd2);
    repeat (10) step();
    chk("arb_cnt", 64'(got.size()), 64'(4));
    if (got.size() >= 4) begin
      chk("arb0_id", 64'(got[0].id), 64'(0));
      chk("arb0_res", 64'(got[0].res), 64'(8'h07));
      chk("arb1_id", 64'(got[1].id), 64'(1));
      chk("arb1_res", 64'(got[1].res), 64'(8'hFA));
      chk("arb2_id", 64'(got[2].id), 64'(0));
    end

    // Signed divide -7 / 2
    got.delete();
    push(1'b0, 2'b11, 4'b1001, 4'd2);
    repeat (6) step();
    chk("div_cnt", 64'(got.size()), 64'(1));
    if (got.size() >= 1) begin
      chk("div_id", 64'(got[0].id), 64'(0));
      chk("div_res", 64'(got[0].res), 64'(8'hFD));
      chk("div_rem", 64'(got[0].rem), 64'(8'hFF));
      chk("div_zd", 64'(got[0].zd), 64'(0));
    end

    // Divide by zero short-circuit
    got.delete();
    push(1'b1, 2'b11, 4'd5, 4'd0);
    repeat (5) step();
    chk("dz_cnt", 64'(got.size()), 64'(1));
    if (got.size() >= 1) begin
      chk("dz_id", 64'(got[0].id), 64'(1));
      chk("dz_res", 64'(got[0].res), 64'(0));
      chk("dz_zd", 64'(got[0].zd), 64'(1));
    end

    // Backpressure with req0 waiting throughout
    rr_val = 1'b0;
    push(1'b0, 2'b10, 4'h7, 4'h7);
    for (int i = 0; i < 20 && !m_vis; i++) step();
    chk("bp_reached_resp", 64'(m_vis), 64'(1));
    push(1'b0, 2'b01, 4'h8, 4'h1);
    repeat (5) step();
    rr_val = 1'b1;
    repeat (8) step();

    // Asynchronous reset while executing
    push(1'b0, 2'b10, 4'h5, 4'h3);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_if.valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dp_op", 64'(dp_if.op), 64'(0));
    chk("rst_dp_a", 64'(dp_if.a), 64'(0));
    chk("rst_dp_b", 64'(dp_if.b), 64'(0));
    chk("rst_rsp_id", 64'(rsp_if.id), 64'(0));
    chk("rst_rsp_result", 64'(rsp_if.result), 64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Random traffic with random response backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) begin
        o.op = 2'($urandom_range(0, 3));
        o.a  = DW'($urandom);
        o.b  = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom);
        q0.push_back(o);
      end
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) begin
        o.op = 2'($urandom_range(0, 3));
        o.a  = DW'($urandom);
        o.b  = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom);
        q1.push_back(o);
      end
      step();
    end
    rr_rand = 1'b0;
    rr_val  = 1'b1;
    repeat (40) step();
    chk("drain_busy", 64'(busy), 64'(0));
    chk("drain_rsp_valid", 64'(rsp_if.valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
